// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel 2-flop synchronizer, debounce counter and FSM.
// Produces a clean level plus single-cycle press/release pulses for each button.
module button_conditioner #(
  parameter int NB_BUTTONS      = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NB_COUNTER      = 24
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NB_BUTTONS-1:0] i_buttons,
  output logic [NB_BUTTONS-1:0] o_buttons_level,
  output logic [NB_BUTTONS-1:0] o_buttons_pulse,
  output logic [NB_BUTTONS-1:0] o_release_pulse
);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [NB_COUNTER-1:0] CNT_LAST = NB_COUNTER'(DEBOUNCE_CYCLES - 1);
  localparam logic [NB_COUNTER-1:0] CNT_ONE  = NB_COUNTER'(1);
  localparam logic [NB_COUNTER-1:0] CNT_ZERO = NB_COUNTER'(0);

  logic [NB_BUTTONS-1:0] sync1_q, sync1_d;
  logic [NB_BUTTONS-1:0] sync2_q, sync2_d;
  logic [NB_BUTTONS-1:0] level_q, level_d;
  logic [NB_BUTTONS-1:0] press_q, press_d;
  logic [NB_BUTTONS-1:0] release_q, release_d;
  state_t                state_q [NB_BUTTONS];
  state_t                state_d [NB_BUTTONS];
  logic [NB_COUNTER-1:0] cnt_q   [NB_BUTTONS];
  logic [NB_COUNTER-1:0] cnt_d   [NB_BUTTONS];

  // Synchronizer chain: only sync2 is seen by the debounce logic.
  always_comb begin
    sync1_d = i_buttons;
    sync2_d = sync1_q;
  end

  // Per-channel debounce FSM; a level change is accepted only after the
  // synchronized input holds the new value for DEBOUNCE_CYCLES samples.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int n = 0; n < NB_BUTTONS; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n];
      case (state_q[n])
        S_LOW: begin
          cnt_d[n] = CNT_ZERO;
          if (sync2_q[n]) begin
            state_d[n] = S_WAIT_HIGH;
            cnt_d[n]   = CNT_ONE;
          end else begin
            state_d[n] = S_LOW;
          end
        end
        S_WAIT_HIGH: begin
          if (!sync2_q[n]) begin
            state_d[n] = S_LOW;
            cnt_d[n]   = CNT_ZERO;
          end else if (cnt_q[n] == CNT_LAST) begin
            state_d[n] = S_HIGH;
            cnt_d[n]   = CNT_ZERO;
            level_d[n] = 1'b1;
            press_d[n] = 1'b1;
          end else begin
            cnt_d[n] = cnt_q[n] + CNT_ONE;
          end
        end
        S_HIGH: begin
          cnt_d[n] = CNT_ZERO;
          if (!sync2_q[n]) begin
            state_d[n] = S_WAIT_LOW;
            cnt_d[n]   = CNT_ONE;
          end else begin
            state_d[n] = S_HIGH;
          end
        end
        S_WAIT_LOW: begin
          if (sync2_q[n]) begin
            state_d[n] = S_HIGH;
            cnt_d[n]   = CNT_ZERO;
          end else if (cnt_q[n] == CNT_LAST) begin
            state_d[n]   = S_LOW;
            cnt_d[n]     = CNT_ZERO;
            level_d[n]   = 1'b0;
            release_d[n] = 1'b1;
          end else begin
            cnt_d[n] = cnt_q[n] + CNT_ONE;
          end
        end
        default: begin
          state_d[n] = S_LOW;
          cnt_d[n]   = CNT_ZERO;
          level_d[n] = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int n = 0; n < NB_BUTTONS; n++) begin
        state_q[n] <= S_LOW;
        cnt_q[n]   <= CNT_ZERO;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int n = 0; n < NB_BUTTONS; n++) begin
        state_q[n] <= state_d[n];
        cnt_q[n]   <= cnt_d[n];
      end
    end
  end

  assign o_buttons_level = level_q;
  assign o_buttons_pulse = press_q;
  assign o_release_pulse = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_button_conditioner;

  localparam int NB = 3;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn = 3'b000;
  logic [NB-1:0] level;
  logic [NB-1:0] pulse;
  logic [NB-1:0] rel;

  int tests_run = 0;
  int failures  = 0;

  button_conditioner #(
    .NB_BUTTONS(NB),
    .DEBOUNCE_CYCLES(DC),
    .NB_COUNTER(24)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .i_buttons(btn),
    .o_buttons_level(level),
    .o_buttons_pulse(pulse),
    .o_release_pulse(rel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 3'b000;
    tick();
    tick();
    tests_run++;
    if ({level, pulse, rel} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, expected %b", {level, pulse, rel}, 9'b0);
    end
  endtask

  // Button 0 held from before the first un-reset edge: level rises after edge 5.
  task automatic test_press();
    int rel_cnt;
    btn = 3'b001;
    tick();
    rst = 1'b0;
    for (int i = 0; i <= DC; i++) begin
      tick();
      tests_run++;
      if (level !== 3'b000 || pulse !== 3'b000) begin
        failures++;
        $display("FAIL press_early edge %0d: level %b pulse %b, expected 000 000", i, level, pulse);
      end
    end
    tick();
    tests_run++;
    if (level !== 3'b001 || pulse !== 3'b001) begin
      failures++;
      $display("FAIL press_edge: level %b pulse %b, expected 001 001", level, pulse);
    end
    tick();
    tests_run++;
    if (level !== 3'b001 || pulse !== 3'b000) begin
      failures++;
      $display("FAIL press_after: level %b pulse %b, expected 001 000", level, pulse);
    end
    btn = 3'b000;
    rel_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rel !== 3'b000) rel_cnt++;
    end
    tests_run++;
    if (rel_cnt !== 1 || level !== 3'b000) begin
      failures++;
      $display("FAIL press_release: release pulses %0d level %b, expected 1 000", rel_cnt, level);
    end
  endtask

  task automatic test_bounce();
    logic [15:0] seq;
    seq = 16'b1110_1100_0000_0000;
    for (int i = 0; i < 16; i++) begin
      btn = {1'b0, seq[15-i], 1'b0};
      tick();
      tests_run++;
      if ({level, pulse, rel} !== 9'b0) begin
        failures++;
        $display("FAIL bounce step %0d: got %b, expected %b", i, {level, pulse, rel}, 9'b0);
      end
    end
  endtask

  task automatic test_hold_release();
    int press_cnt;
    press_cnt = 0;
    btn = 3'b100;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pulse === 3'b100) press_cnt++;
    end
    tests_run++;
    if (press_cnt !== 1 || level !== 3'b100) begin
      failures++;
      $display("FAIL hold: press pulses %0d level %b, expected 1 100", press_cnt, level);
    end
    btn = 3'b000;
    for (int i = 0; i <= DC; i++) begin
      tick();
      tests_run++;
      if (level !== 3'b100 || rel !== 3'b000) begin
        failures++;
        $display("FAIL release_early edge %0d: level %b rel %b, expected 100 000", i, level, rel);
      end
    end
    tick();
    tests_run++;
    if (level !== 3'b000 || rel !== 3'b100 || pulse !== 3'b000) begin
      failures++;
      $display("FAIL release_edge: level %b rel %b pulse %b, expected 000 100 000", level, rel, pulse);
    end
    tick();
    tests_run++;
    if (rel !== 3'b000 || pulse !== 3'b000) begin
      failures++;
      $display("FAIL release_after: rel %b pulse %b, expected 000 000", rel, pulse);
    end
  endtask

  task automatic test_simultaneous();
    int all_cnt;
    int bad_cnt;
    all_cnt = 0;
    bad_cnt = 0;
    btn = 3'b111;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (pulse === 3'b111) all_cnt++;
      else if (pulse !== 3'b000) bad_cnt++;
    end
    tests_run++;
    if (all_cnt !== 1 || bad_cnt !== 0 || level !== 3'b111) begin
      failures++;
      $display("FAIL simultaneous: full pulses %0d partial %0d level %b, expected 1 0 111", all_cnt, bad_cnt, level);
    end
    btn = 3'b000;
    for (int i = 0; i < 12; i++) tick();
    tests_run++;
    if (level !== 3'b000) begin
      failures++;
      $display("FAIL simultaneous_release: level %b, expected 000", level);
    end
  endtask

  // Reset with channel 0 at count 2; the held button re-debounces from scratch.
  task automatic test_reset_mid_count();
    btn = 3'b001;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    tests_run++;
    if ({level, pulse, rel} !== 9'b0) begin
      failures++;
      $display("FAIL midreset_outputs: got %b, expected %b", {level, pulse, rel}, 9'b0);
    end
    rst = 1'b0;
    for (int i = 0; i <= DC; i++) begin
      tick();
      tests_run++;
      if (level !== 3'b000 || pulse !== 3'b000) begin
        failures++;
        $display("FAIL midreset_early edge %0d: level %b pulse %b, expected 000 000", i, level, pulse);
      end
    end
    tick();
    tests_run++;
    if (level !== 3'b001 || pulse !== 3'b001) begin
      failures++;
      $display("FAIL midreset_press: level %b pulse %b, expected 001 001", level, pulse);
    end
    tick();
    tests_run++;
    if (pulse !== 3'b000) begin
      failures++;
      $display("FAIL midreset_after: pulse %b, expected 000", pulse);
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_hold_release();
    test_simultaneous();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
